// File: rtl/upsp_pixel_sequencer_pkg.sv
// Shared types for the upsampler pixel sequencer: FSM encoding, tagged-pixel record, coordinate widths.
// The tag record is sized for the default (largest) geometry; smaller builds zero-extend into it.
package upsp_pkg;

  localparam int TAG_DATA_W         = 24;
  localparam int DEF_SRC_IMG_WIDTH  = 960;
  localparam int DEF_SRC_IMG_HEIGHT = 540;
  localparam int DEF_FIFO_DEPTH     = 4;

  // A one-pixel-wide image still needs a 1-bit coordinate.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int X_W = clog2_min1(DEF_SRC_IMG_WIDTH);
  localparam int Y_W = clog2_min1(DEF_SRC_IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [TAG_DATA_W-1:0] data;
    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic                  eol;
    logic                  eof;
  } px_tag_t;

endpackage

// File: rtl/upsp_pixel_sequencer_if.sv
// Pixel handshakes around the sequencer: access_control read port in, tagged-pixel stream out.
// master = sequencer side, slave = the surrounding access_control/upsampler side.
interface upsp_pixel_sequencer_if #(
  parameter int DATA_W = 24,
  parameter int X_BITS = 10,
  parameter int Y_BITS = 10
);
  logic              ac_upsp_rvalid;
  logic [DATA_W-1:0] ac_upsp_rdata;
  logic              upsp_ac_rready;
  logic              px_valid;
  logic [DATA_W-1:0] px_data;
  logic [X_BITS-1:0] px_x;
  logic [Y_BITS-1:0] px_y;
  logic              px_eol;
  logic              px_eof;
  logic              px_ready;

  modport master (
    input  ac_upsp_rvalid, ac_upsp_rdata, px_ready,
    output upsp_ac_rready, px_valid, px_data, px_x, px_y, px_eol, px_eof
  );

  modport slave (
    output ac_upsp_rvalid, ac_upsp_rdata, px_ready,
    input  upsp_ac_rready, px_valid, px_data, px_x, px_y, px_eol, px_eof
  );
endinterface

// File: rtl/upsp_pixel_sequencer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
// Pushes into a full FIFO and pops from an empty one are ignored.
module upsp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign w_push  = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // NOTE: storage has no reset; an entry is only ever read after it was written, and the count is reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/upsp_pixel_sequencer.sv
// Tags access_control pixels with (x, y, eol, eof), buffers them for the upsampler, pulses frame_done when drained.
// Optional: define UPSP_SEQ_PERF_EN to add the stall_cycles performance counter port.
module upsp_pixel_sequencer
  import upsp_pkg::*;
#(
  parameter int UPSP_DATA_WIDTH = TAG_DATA_W,
  parameter int SRC_IMG_WIDTH   = DEF_SRC_IMG_WIDTH,
  parameter int SRC_IMG_HEIGHT  = DEF_SRC_IMG_HEIGHT,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   seq_start,
  upsp_pixel_sequencer_if.master bus,
  output logic                   seq_busy,
  output logic                   frame_done
`ifdef UPSP_SEQ_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);
  localparam int XB = clog2_min1(SRC_IMG_WIDTH);
  localparam int YB = clog2_min1(SRC_IMG_HEIGHT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]    r_state;
  logic [XB-1:0] r_x;
  logic [YB-1:0] r_y;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_rready;
  logic          w_accept;
  logic          w_pop;
  logic          w_eol;
  logic          w_eof;
  px_tag_t       w_wr_tag;
  px_tag_t       w_rd_tag;

  // Registered-only ready: a full FIFO blocks this cycle even if the head pops.
  assign w_rready = (r_state == ST_RUN) && (w_count < CW'(FIFO_DEPTH));
  assign w_accept = bus.ac_upsp_rvalid && w_rready;
  assign w_pop    = !w_empty && bus.px_ready;
  assign w_eol    = (r_x == XB'(SRC_IMG_WIDTH - 1));
  assign w_eof    = w_eol && (r_y == YB'(SRC_IMG_HEIGHT - 1));

  always_comb begin
    // NOTE: default the whole record first so no path through this block can infer a latch.
    w_wr_tag      = '0;
    w_wr_tag.data = TAG_DATA_W'(bus.ac_upsp_rdata);
    w_wr_tag.x    = X_W'(r_x);
    w_wr_tag.y    = Y_W'(r_y);
    w_wr_tag.eol  = w_eol;
    w_wr_tag.eof  = w_eof;
  end

  upsp_sync_fifo #(
    .WIDTH ($bits(px_tag_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_wdata (w_wr_tag),
    .i_pop   (w_pop),
    .o_rdata (w_rd_tag),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (seq_start) begin
            r_state <= ST_RUN;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_eol) begin
              r_x <= '0;
              if (w_eof) r_state <= ST_DRAIN;
              else       r_y     <= r_y + YB'(1);
            end else begin
              r_x <= r_x + XB'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign frame_done         = (r_state == ST_DRAIN) && w_empty;
  assign seq_busy           = (r_state != ST_IDLE);
  assign bus.upsp_ac_rready = w_rready;

  // Head fields read as zero while empty so the stream is clean out of reset.
  assign bus.px_valid = !w_empty;
  assign bus.px_data  = w_empty ? '0 : UPSP_DATA_WIDTH'(w_rd_tag.data);
  assign bus.px_x     = w_empty ? '0 : XB'(w_rd_tag.x);
  assign bus.px_y     = w_empty ? '0 : YB'(w_rd_tag.y);
  assign bus.px_eol   = !w_empty && w_rd_tag.eol;
  assign bus.px_eof   = !w_empty && w_rd_tag.eof;

`ifdef UPSP_SEQ_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if ((r_state == ST_IDLE) && seq_start) begin
      r_stall_cycles <= '0;
    end else if ((r_state == ST_RUN) && bus.ac_upsp_rvalid && !w_rready &&
                 (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/upsp_pixel_sequencer.md
Name: upsp_pixel_sequencer

Overview:
Downstream neighbour of access_control on its upsampler read port (ac_upsp_rvalid / ac_upsp_rdata / upsp_ac_rready).
- Accepts source pixels one at a time and tags each with its (x, y) source coordinate and end-of-row / end-of-frame flags.
- Buffers tagged pixels in a small FIFO so that upsampler back-pressure is decoupled from access_control.
- Signals frame completion once every pixel of a frame has been consumed downstream.

Parameters:
UPSP_DATA_WIDTH, 24, pixel width (RGB888).
SRC_IMG_WIDTH, 960, source pixels per row.
SRC_IMG_HEIGHT, 540, source rows per frame.
FIFO_DEPTH, 4, tagged-pixel FIFO entries; power of two, at least 2.

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
seq_start  in  1  one-cycle pulse that starts a frame (driven by the UPSTART condition)
ac_upsp_rvalid  in  1  pixel from access_control is valid
ac_upsp_rdata  in  UPSP_DATA_WIDTH  pixel data
upsp_ac_rready  out  1  sequencer accepts a pixel
px_valid  out  1  tagged pixel available
px_data  out  UPSP_DATA_WIDTH  pixel data
px_x  out  $clog2(SRC_IMG_WIDTH)  source column
px_y  out  $clog2(SRC_IMG_HEIGHT)  source row
px_eol  out  1  last pixel of its row
px_eof  out  1  last pixel of the frame
px_ready  in  1  upsampler consumes the tagged pixel
seq_busy  out  1  state is not IDLE
frame_done  out  1  one-cycle pulse when the frame is fully drained

Behaviour:
- Reset: state IDLE; x and y counters 0; FIFO empty.
  - upsp_ac_rready, px_valid, px_eol, px_eof, seq_busy and frame_done are 0.
  - px_data, px_x and px_y are 0.
- Reset asserted mid-frame aborts the frame immediately. The FIFO contents are discarded and no frame_done is issued.
- State machine:
  - IDLE: on seq_start go to RUN and clear x and y.
  - RUN: accept pixels. When the pixel at (SRC_IMG_WIDTH-1, SRC_IMG_HEIGHT-1) is accepted, go to DRAIN.
  - DRAIN: accept nothing. When the FIFO becomes empty (the last pop has completed), pulse frame_done for one cycle and go to IDLE.
  - seq_start is ignored outside IDLE.
- upsp_ac_rready = (state == RUN) & (fifo_count < FIFO_DEPTH). It is derived from registered state only and does not depend on px_ready in the same cycle.
  - When the FIFO is full, rready stays 0 even if a pop happens in that cycle. This is a one-cycle bubble and is intended.
- A pixel is accepted only on ac_upsp_rvalid & upsp_ac_rready.
- On accept, the FIFO entry is written as {data, x, y, eol = (x == W-1), eof = eol & (y == H-1)}.
  - x then increments. When x is W-1, x wraps to 0 and y increments.
  - y does not wrap inside a frame; the state moves to DRAIN instead.
- FIFO is first-word-fall-through:
  - px_valid = !empty, and px_* show the head entry.
  - A pop happens on px_valid & px_ready.
  - Push and pop in the same cycle keep the count unchanged and are allowed whenever the count is between 1 and DEPTH-1.
  - Latency from accept to px_valid is exactly 1 cycle when the FIFO is empty.
- px_* hold stable while px_valid=1 and px_ready=0 (AXI-style).
- seq_busy = (state != IDLE).
- frame_done and seq_start in the same cycle: frame_done fires and the state returns to IDLE. The start is not taken because it arrived while the block was not in IDLE.

Optional Feature:
Macro UPSP_SEQ_PERF_EN.
- Defined:
  - Adds output stall_cycles (32 bits). It counts cycles in RUN where ac_upsp_rvalid=1 and upsp_ac_rready=0.
  - It clears on seq_start and saturates at 32'hFFFF_FFFF.
  - Reset value is 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package upsp_pkg:
  - typedef seq_state_e {IDLE, RUN, DRAIN}.
  - typedef struct px_tag_t {data, x, y, eol, eof}.
  - localparams X_W and Y_W for the coordinate widths.
- One sub-module, upsp_sync_fifo: parameterised width and depth, first-word fall-through, with count output. The top holds the FSM and counters.

Test Plan:
1. W=4, H=2, DEPTH=4, px_ready=1, rvalid held 1, data 1..8 → px outputs (0,0)…(3,1) in order. eol is set on data 4 and 8; eof only on data 8. frame_done pulses 1 cycle after the last pop. rready is 0 after pixel 8.
2. Same parameters with px_ready=0 → exactly 4 pixels accepted, then rready=0. Raise px_ready → one pixel pops per cycle, and rready returns the cycle after the count drops below 4.
3. Random rvalid and px_ready at 50% each, W=5, H=3 → 15 pixels in order with correct coordinates. px_* stable during stalls. Exactly one frame_done.
4. seq_start during RUN and again on the frame_done cycle → both ignored: no counter clear and no new frame. A seq_start after IDLE is reached starts a new frame with x=y=0.
5. rst_n asserted after 3 of 8 pixels → all outputs reach their reset values immediately and no frame_done occurs. A subsequent seq_start restarts the frame from (0,0).
6. UPSP_SEQ_PERF_EN defined, FIFO held full with rvalid=1 for 10 cycles → stall_cycles=10, and it clears to 0 on the next seq_start.
